// File: rtl/axil_config_writer.sv
// AXI4-Lite write-channel slave that converts each accepted host write into a
// single-cycle config bus pulse, with OKAY/SLVERR/DECERR write responses.
module axil_config_writer #(
   parameter int AXIL_ADDR_WIDTH = 16,
   parameter int DATA_WIDTH      = 64,
   parameter int NUM_REGS        = 64,
   localparam int STRB_W         = DATA_WIDTH / 8,
   localparam int CFG_ADDR_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
   input  logic                       s_axil_awvalid,
   output logic                       s_axil_awready,
   input  logic [DATA_WIDTH-1:0]      s_axil_wdata,
   input  logic [STRB_W-1:0]          s_axil_wstrb,
   input  logic                       s_axil_wvalid,
   output logic                       s_axil_wready,
   output logic [1:0]                 s_axil_bresp,
   output logic                       s_axil_bvalid,
   input  logic                       s_axil_bready,
   output logic                       write_config_valid,
   output logic [CFG_ADDR_W-1:0]      write_config_addr,
   output logic [DATA_WIDTH-1:0]      write_config_data
);

   // state | meaning
   // IDLE  | collecting AW and W independently into holding regs
   // ISSUE | one cycle: classify held write, pulse config bus if legal
   // RESP  | bvalid high until bready
   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP} state_t;

   localparam int OFS_W = $clog2(STRB_W);
   localparam int IDX_W = AXIL_ADDR_WIDTH - OFS_W;
   localparam logic [IDX_W-1:0] NUM_REGS_IDX = IDX_W'(NUM_REGS);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   state_t                  state_q, state_d;
   logic                    aw_held_q, aw_held_d;
   logic                    w_held_q, w_held_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    wfull_q, wfull_d;
   logic                    cfg_valid_q, cfg_valid_d;
   logic [CFG_ADDR_W-1:0]   cfg_addr_q, cfg_addr_d;
   logic [DATA_WIDTH-1:0]   cfg_data_q, cfg_data_d;
   logic [1:0]              bresp_q, bresp_d;

   logic                    aw_rdy, w_rdy, b_vld;
   logic                    aw_fire, w_fire;
   logic [IDX_W-1:0]        in_idx, eff_idx;
   logic [DATA_WIDTH-1:0]   eff_data;
   logic                    in_full, eff_full;
   logic                    unused_addr_bits;

   assign unused_addr_bits = ^s_axil_awaddr[OFS_W-1:0];

   assign in_idx   = s_axil_awaddr[AXIL_ADDR_WIDTH-1:OFS_W];
   assign in_full  = (s_axil_wstrb == {STRB_W{1'b1}});
   assign aw_fire  = s_axil_awvalid && aw_rdy;
   assign w_fire   = s_axil_wvalid && w_rdy;

   // Classification must see a channel that is arriving in the same edge it completes the pair.
   assign eff_idx  = aw_held_q ? idx_q   : in_idx;
   assign eff_data = w_held_q  ? wdata_q : s_axil_wdata;
   assign eff_full = w_held_q  ? wfull_q : in_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_RESP;
         ST_RESP:  if (s_axil_bready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      aw_rdy = 1'b0;
      w_rdy  = 1'b0;
      b_vld  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            aw_rdy = !aw_held_q && !rst;
            w_rdy  = !w_held_q && !rst;
         end
         ST_RESP: b_vld = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      aw_held_d   = aw_held_q;
      w_held_d    = w_held_q;
      idx_d       = idx_q;
      wdata_d     = wdata_q;
      wfull_d     = wfull_q;
      cfg_valid_d = 1'b0;
      cfg_addr_d  = cfg_addr_q;
      cfg_data_d  = cfg_data_q;
      bresp_d     = bresp_q;
      if (aw_fire) begin
         aw_held_d = 1'b1;
         idx_d     = in_idx;
      end
      if (w_fire) begin
         w_held_d = 1'b1;
         wdata_d  = s_axil_wdata;
         wfull_d  = in_full;
      end
      if (state_q == ST_IDLE && state_d == ST_ISSUE) begin
         if (eff_idx >= NUM_REGS_IDX) begin
            bresp_d = RESP_DECERR;
         end else if (!eff_full) begin
            bresp_d = RESP_SLVERR;
         end else begin
            bresp_d     = RESP_OKAY;
            cfg_valid_d = 1'b1;
            cfg_addr_d  = eff_idx[CFG_ADDR_W-1:0];
            cfg_data_d  = eff_data;
         end
      end
      if (state_q == ST_RESP && s_axil_bready) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         aw_held_q   <= 1'b0;
         w_held_q    <= 1'b0;
         idx_q       <= '0;
         wdata_q     <= '0;
         wfull_q     <= 1'b0;
         cfg_valid_q <= 1'b0;
         cfg_addr_q  <= '0;
         cfg_data_q  <= '0;
         bresp_q     <= RESP_OKAY;
      end else begin
         aw_held_q   <= aw_held_d;
         w_held_q    <= w_held_d;
         idx_q       <= idx_d;
         wdata_q     <= wdata_d;
         wfull_q     <= wfull_d;
         cfg_valid_q <= cfg_valid_d;
         cfg_addr_q  <= cfg_addr_d;
         cfg_data_q  <= cfg_data_d;
         bresp_q     <= bresp_d;
      end
   end

   assign s_axil_awready     = aw_rdy;
   assign s_axil_wready      = w_rdy;
   assign s_axil_bvalid      = b_vld;
   assign s_axil_bresp       = bresp_q;
   assign write_config_valid = cfg_valid_q;
   assign write_config_addr  = cfg_addr_q;
   assign write_config_data  = cfg_data_q;

endmodule

// File: tb/tb_axil_config_writer.sv
// Bench for axil_config_writer: transaction-level timing model checked every cycle,
// plus directed scenarios with hand-computed pulse/response expectations.
module tb_axil_config_writer;
   localparam int AW = 16;
   localparam int DW = 64;
   localparam int NR = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] s_axil_awaddr = '0;
   logic          s_axil_awvalid = 1'b0;
   logic          s_axil_awready;
   logic [DW-1:0] s_axil_wdata = '0;
   logic [7:0]    s_axil_wstrb = '0;
   logic          s_axil_wvalid = 1'b0;
   logic          s_axil_wready;
   logic [1:0]    s_axil_bresp;
   logic          s_axil_bvalid;
   logic          s_axil_bready = 1'b1;
   logic          write_config_valid;
   logic [5:0]    write_config_addr;
   logic [DW-1:0] write_config_data;

   axil_config_writer #(.AXIL_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
      .clk(clk), .rst(rst),
      .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
      .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
      .s_axil_wready(s_axil_wready),
      .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
      .write_config_valid(write_config_valid), .write_config_addr(write_config_addr),
      .write_config_data(write_config_data)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // Model: at most one transaction in flight, pulse expected in the cycle after the pair completes.
   bit            m_aw_have = 0, m_w_have = 0, m_busy = 0, m_legal = 0;
   int            m_idx = 0, m_issue_cyc = 0;
   logic [DW-1:0] m_wdata = '0, m_data = '0;
   logic [7:0]    m_wstrb = '0;
   int            m_addr = 0;
   logic [1:0]    m_bresp = 2'b00;

   int            p_cyc[$];
   int            p_addr[$];
   logic [DW-1:0] p_data[$];
   int            b_cyc[$];
   logic [1:0]    b_resp[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_busy = 0; m_aw_have = 0; m_w_have = 0;
         m_addr = 0; m_data = '0; m_bresp = 2'b00; m_legal = 0;
      end else if (m_busy) begin
         if (cyc > m_issue_cyc && s_axil_bready) begin
            m_busy = 0; m_aw_have = 0; m_w_have = 0;
         end
      end else begin
         if (s_axil_awvalid && !m_aw_have) begin
            m_aw_have = 1;
            m_idx = int'(s_axil_awaddr) / (DW / 8);
         end
         if (s_axil_wvalid && !m_w_have) begin
            m_w_have = 1;
            m_wdata = s_axil_wdata;
            m_wstrb = s_axil_wstrb;
         end
         if (m_aw_have && m_w_have) begin
            m_busy = 1;
            m_issue_cyc = cyc + 1;
            if (m_idx >= NR) begin
               m_bresp = 2'b11; m_legal = 0;
            end else if (m_wstrb != 8'hFF) begin
               m_bresp = 2'b10; m_legal = 0;
            end else begin
               m_bresp = 2'b00; m_legal = 1;
               m_addr = m_idx; m_data = m_wdata;
            end
         end
      end
      cyc++;
   end

   always @(negedge clk) begin
      bit exp_rdy_ok, exp_v, exp_bv;
      exp_rdy_ok = !rst && !m_busy;
      exp_v  = m_busy && (cyc == m_issue_cyc) && m_legal;
      exp_bv = m_busy && (cyc > m_issue_cyc);
      chk("awready", s_axil_awready, exp_rdy_ok && !m_aw_have);
      chk("wready", s_axil_wready, exp_rdy_ok && !m_w_have);
      chk("cfg_valid", write_config_valid, exp_v);
      chk("bvalid", s_axil_bvalid, exp_bv);
      if (exp_bv) chk("bresp", s_axil_bresp, m_bresp);
      chk("cfg_addr", write_config_addr, m_addr);
      chk("cfg_data", write_config_data, m_data);
      if (write_config_valid) begin
         p_cyc.push_back(cyc); p_addr.push_back(int'(write_config_addr));
         p_data.push_back(write_config_data);
      end
      if (s_axil_bvalid && s_axil_bready) begin
         b_cyc.push_back(cyc); b_resp.push_back(s_axil_bresp);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_aw(input logic [AW-1:0] a, output int acc);
      bit ok = 0;
      int n = 0;
      acc = -1;
      s_axil_awaddr = a; s_axil_awvalid = 1'b1;
      while (!ok && n < 60) begin
         @(negedge clk);
         if (s_axil_awready) begin ok = 1; acc = cyc; end
         @(posedge clk); #1;
         n++;
      end
      s_axil_awvalid = 1'b0;
      chk("aw_accept", ok, 1);
   endtask

   task automatic send_w(input logic [DW-1:0] d, input logic [7:0] s, output int acc);
      bit ok = 0;
      int n = 0;
      acc = -1;
      s_axil_wdata = d; s_axil_wstrb = s; s_axil_wvalid = 1'b1;
      while (!ok && n < 60) begin
         @(negedge clk);
         if (s_axil_wready) begin ok = 1; acc = cyc; end
         @(posedge clk); #1;
         n++;
      end
      s_axil_wvalid = 1'b0;
      chk("w_accept", ok, 1);
   endtask

   task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [7:0] s,
                        output int acc);
      int a1, a2;
      fork
         send_aw(a, a1);
         send_w(d, s, a2);
      join
      acc = (a1 > a2) ? a1 : a2;
   endtask

   function automatic int pc(input int i);
      return (i < p_cyc.size()) ? p_cyc[i] : -1;
   endfunction
   function automatic int pa(input int i);
      return (i < p_addr.size()) ? p_addr[i] : -1;
   endfunction
   function automatic int bc(input int i);
      return (i < b_cyc.size()) ? b_cyc[i] : -1;
   endfunction
   function automatic logic [1:0] br(input int i);
      return (i < b_resp.size()) ? b_resp[i] : 2'bxx;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      int acc, acc2, np, nb, wacc, a1, a2, prs;
      int accs[8];

      // reset values
      step(2);
      @(negedge clk);
      chk("rst_awready", s_axil_awready, 0);
      chk("rst_wready", s_axil_wready, 0);
      chk("rst_bvalid", s_axil_bvalid, 0);
      chk("rst_bresp", s_axil_bresp, 0);
      chk("rst_cfg_valid", write_config_valid, 0);
      chk("rst_cfg_addr", write_config_addr, 0);
      chk("rst_cfg_data", write_config_data, 0);
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      chk("post_rst_awready", s_axil_awready, 1);
      chk("post_rst_wready", s_axil_wready, 1);
      @(posedge clk); #1;

      // 1: same-cycle AW/W
      np = p_cyc.size(); nb = b_cyc.size();
      write(16'h0018, 64'hDEADBEEF_0000_0001, 8'hFF, acc);
      step(4);
      chk("t1_npulse", p_cyc.size() - np, 1);
      chk("t1_pulse_cyc", pc(np), acc + 1);
      chk("t1_addr", pa(np), 3);
      chk("t1_data", (np < p_data.size()) ? p_data[np] : '0, 64'hDEADBEEF_0000_0001);
      chk("t1_b_cyc", bc(nb), acc + 2);
      chk("t1_bresp", br(nb), 2'b00);

      // 2: W five cycles before AW
      np = p_cyc.size();
      send_w(64'h1122_3344_5566_7788, 8'hFF, wacc);
      @(negedge clk);
      chk("t2_wready_low", s_axil_wready, 0);
      chk("t2_awready_high", s_axil_awready, 1);
      @(posedge clk); #1;
      step(3);
      send_aw(16'h0000, acc);
      step(4);
      chk("t2_gap", acc - wacc, 5);
      chk("t2_npulse", p_cyc.size() - np, 1);
      chk("t2_pulse_cyc", pc(np), acc + 1);
      chk("t2_addr", pa(np), 0);

      // 3: SLVERR and DECERR
      np = p_cyc.size(); nb = b_cyc.size();
      write(16'h0010, 64'h0BAD, 8'h0F, acc);
      step(4);
      write(16'(NR * 8), 64'h0BAD, 8'hFF, acc);
      step(4);
      chk("t3_npulse", p_cyc.size() - np, 0);
      chk("t3_bresp_slverr", br(nb), 2'b10);
      chk("t3_bresp_decerr", br(nb + 1), 2'b11);
      chk("t3_addr_held", write_config_addr, 0);

      // 4: bready stall, new write offered meanwhile
      nb = b_cyc.size(); np = p_cyc.size();
      s_axil_bready = 1'b0;
      write(16'h0020, 64'hCAFE_0004, 8'hFF, acc);
      step(1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t4_bvalid_hold", s_axil_bvalid, 1);
         chk("t4_bresp_hold", s_axil_bresp, 2'b00);
         chk("t4_awready_low", s_axil_awready, 0);
      end
      @(posedge clk); #1;
      fork
         send_aw(16'h0028, a1);
         send_w(64'hCAFE_0005, 8'hFF, a2);
         begin step(3); s_axil_bready = 1'b1; end
      join
      step(4);
      chk("t4_accept_after_b", a1 - bc(nb), 1);
      chk("t4_w_accept_after_b", a2 - bc(nb), 1);
      chk("t4_b_first", br(nb), 2'b00);
      chk("t4_npulse", p_cyc.size() - np, 2);
      chk("t4_addr2", pa(np + 1), 5);

      // 5: back-to-back
      np = p_cyc.size();
      for (int i = 0; i < 8; i++)
         write(16'(i * 8), {32'hA5A5_0000, 32'(i)}, 8'hFF, accs[i]);
      step(4);
      chk("t5_npulse", p_cyc.size() - np, 8);
      for (int i = 0; i < 8; i++) begin
         chk("t5_addr", pa(np + i), i);
         if (i > 0) chk("t5_spacing", pc(np + i) - pc(np + i - 1), 3);
      end

      // 6a: reset during ISSUE
      write(16'h0030, 64'h6A6A, 8'hFF, acc);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      np = p_cyc.size(); nb = b_cyc.size();
      chk("t6a_issue_pulse", pc(np - 1), acc + 1);
      @(negedge clk);
      chk("t6a_cfg_valid", write_config_valid, 0);
      chk("t6a_bvalid", s_axil_bvalid, 0);
      chk("t6a_addr_cleared", write_config_addr, 0);
      @(posedge clk); #1;
      step(5);
      chk("t6a_no_pulse", p_cyc.size() - np, 0);
      chk("t6a_no_b", b_cyc.size() - nb, 0);

      // 6b: reset during RESP
      s_axil_bready = 1'b0;
      write(16'h0038, 64'h6B6B, 8'hFF, acc);
      step(1);
      rst = 1'b1;
      step(1);
      rst = 1'b0; s_axil_bready = 1'b1;
      np = p_cyc.size(); nb = b_cyc.size();
      step(5);
      chk("t6b_no_pulse", p_cyc.size() - np, 0);
      chk("t6b_no_b", b_cyc.size() - nb, 0);
      write(16'h0008, 64'h0000_0000_0000_0F0F, 8'hFF, acc2);
      step(4);
      chk("t6b_recover_pulse", pa(np), 1);
      chk("t6b_recover_cyc", pc(np), acc2 + 1);
      prs = b_cyc.size() - nb;
      chk("t6b_recover_b", prs, 1);
      chk("t6b_recover_bresp", br(nb), 2'b00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
